ir_queue: RTL and testbench

//   Parametrised instruction register queue between instruction memory and the control unit.

---
 rtl/ir_queue_pkg.sv | 29 ++
 rtl/ir_queue_if.sv | 35 +++
 rtl/ir_queue_decode.sv | 36 +++
 rtl/ir_queue.sv | 94 +++++++++
 tb/tb_ir_queue.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ir_queue_pkg.sv
// Field positions and decode helpers for MIPS instruction words held in the queue.
package mips_ir_pkg;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SH_HI    = 10;
  localparam int unsigned SH_LO    = 6;
  localparam int unsigned FN_HI    = 5;
  localparam int unsigned FN_LO    = 0;
  localparam int unsigned IMM16_HI = 15;
  localparam int unsigned IMM26_HI = 25;

  localparam logic [5:0] RTYPE_OP = 6'd0;

  // R-type words decode on funct (LSB set); all others on opcode (LSB clear).
  function automatic logic [6:0] decd_op(input logic [31:0] w);
    if (w[OP_HI:OP_LO] == RTYPE_OP) begin
      return {w[FN_HI:FN_LO], 1'b1};
    end
    return {w[OP_HI:OP_LO], 1'b0};
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Producer/consumer handshake and decoded head fields of the instruction queue.
interface ir_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ins;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [15:0]      imm16;
  logic [25:0]      imm26;
  logic [6:0]       decdOp;
  logic [CNT_W-1:0] count;

  // Producer/consumer side (fetch unit and control unit).
  modport master (
    output in_valid, ins, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs, rt, rd, shamt, imm16, imm26, decdOp, count
  );

  // Queue side.
  modport slave (
    input  in_valid, ins, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs, rt, rd, shamt, imm16, imm26, decdOp, count
  );
endinterface

// File: rtl/ir_queue_decode.sv
// Combinational field extraction for the head word; all fields read 0 when not valid.
module ir_decode
  import mips_ir_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic        valid_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [15:0] imm16_o,
  output logic [25:0] imm26_o,
  output logic [6:0]  decd_op_o
);

  // Slice fields, gated by valid so consumers never see stale storage.
  always_comb begin
    rs_o      = '0;
    rt_o      = '0;
    rd_o      = '0;
    shamt_o   = '0;
    imm16_o   = '0;
    imm26_o   = '0;
    decd_op_o = '0;
    if (valid_i) begin
      rs_o      = word_i[RS_HI:RS_LO];
      rt_o      = word_i[RT_HI:RT_LO];
      rd_o      = word_i[RD_HI:RD_LO];
      shamt_o   = word_i[SH_HI:SH_LO];
      imm16_o   = word_i[IMM16_HI:0];
      imm26_o   = word_i[IMM26_HI:0];
      decd_op_o = decd_op(word_i);
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: DEPTH-entry FIFO of {word, pc} with flush and head decode.
module ir_queue
  import mips_ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  ir_queue_if.slave   q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]     ins_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic in_ready, out_valid, enq, deq;
  logic [31:0] head_word;

  // Handshake; enqueue is refused while full even if the head retires this cycle.
  always_comb begin
    in_ready  = (count_q != FULL_CNT) && !flush && !clr;
    out_valid = (count_q != '0) && !clr;
    enq       = q.in_valid && in_ready;
    deq       = out_valid && q.out_ready;
    head_word = ins_mem_q[rd_ptr_q];
  end

  // Pointer and occupancy next state; clr and flush both discard the cycle's transfers.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq) count_d = count_q + 1'b1;
      if (deq && !enq) count_d = count_q - 1'b1;
    end
  end

  // Control state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      ins_mem_q[wr_ptr_q] <= q.ins;
      pc_mem_q[wr_ptr_q]  <= q.in_pc;
    end
  end

  // Drive handshake outputs and the gated head PC.
  always_comb begin
    q.in_ready  = in_ready;
    q.out_valid = out_valid;
    q.count     = count_q;
    q.out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  end

  ir_decode u_decode (
    .word_i    (head_word),
    .valid_i   (out_valid),
    .rs_o      (q.rs),
    .rt_o      (q.rt),
    .rd_o      (q.rd),
    .shamt_o   (q.shamt),
    .imm16_o   (q.imm16),
    .imm26_o   (q.imm26),
    .decd_op_o (q.decdOp)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (DEPTH=4, PC_W=32).
module tb_ir_queue;
  logic clk = 1'b0;
  logic clr;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  ir_queue_if #(.DEPTH(4), .PC_W(32)) qif ();

  ir_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .q     (qif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] pc);
    qif.in_valid = 1'b1;
    qif.ins      = w;
    qif.in_pc    = pc;
  endtask

  initial begin
    clr           = 1'b1;
    flush         = 1'b0;
    qif.in_valid  = 1'b1;
    qif.ins       = 32'hDEADBEEF;
    qif.in_pc     = 32'h0;
    qif.out_ready = 1'b0;

    // 1. Reset with in_valid held high
    step();
    step();
    check("rst_count", 64'(qif.count), 64'd0);
    check("rst_out_valid", 64'(qif.out_valid), 64'd0);
    check("rst_in_ready", 64'(qif.in_ready), 64'd0);
    check("rst_decdop", 64'(qif.decdOp), 64'd0);
    check("rst_out_pc", 64'(qif.out_pc), 64'd0);
    clr          = 1'b0;
    qif.in_valid = 1'b0;
    #1;
    check("idle_in_ready", 64'(qif.in_ready), 64'd1);

    // 2. R-type: add $8,$9,$10
    offer(32'h012A4020, 32'h100);
    step();
    qif.in_valid = 1'b0;
    check("add_out_valid", 64'(qif.out_valid), 64'd1);
    check("add_rs", 64'(qif.rs), 64'd9);
    check("add_rt", 64'(qif.rt), 64'd10);
    check("add_rd", 64'(qif.rd), 64'd8);
    check("add_shamt", 64'(qif.shamt), 64'd0);
    check("add_decdop", 64'(qif.decdOp), 64'h41);
    check("add_out_pc", 64'(qif.out_pc), 64'h100);
    check("add_count", 64'(qif.count), 64'd1);
    qif.out_ready = 1'b1;
    step();
    qif.out_ready = 1'b0;
    check("add_drained_valid", 64'(qif.out_valid), 64'd0);
    check("add_drained_pc", 64'(qif.out_pc), 64'd0);
    check("add_drained_rs", 64'(qif.rs), 64'd0);

    // 3. I-type: lw $10,4($8)
    offer(32'h8D0A0004, 32'h104);
    step();
    qif.in_valid = 1'b0;
    check("lw_decdop", 64'(qif.decdOp), 64'h46);
    check("lw_imm16", 64'(qif.imm16), 64'h0004);
    check("lw_rt", 64'(qif.rt), 64'd10);
    check("lw_rs", 64'(qif.rs), 64'd8);
    check("lw_imm26", 64'(qif.imm26), 64'h10A0004);
    qif.out_ready = 1'b1;
    step();
    qif.out_ready = 1'b0;

    // 4. Fill (pointers start at 2, so this wraps), hold a 5th, then refill across the wrap
    for (int i = 0; i < 4; i++) begin
      offer(32'h20000000 | 32'(i), 32'h200 + 32'(4 * i));
      step();
    end
    check("full_count", 64'(qif.count), 64'd4);
    check("full_in_ready", 64'(qif.in_ready), 64'd0);
    offer(32'h20000004, 32'h210);
    step();
    check("held_count", 64'(qif.count), 64'd4);
    check("held_head_pc", 64'(qif.out_pc), 64'h200);
    // Dequeue two while the 5th word stays offered: dequeuing while full must not enqueue.
    qif.out_ready = 1'b1;
    step();
    check("full_deq_count", 64'(qif.count), 64'd3);
    qif.in_valid = 1'b0;
    step();
    qif.out_ready = 1'b0;
    check("deq2_count", 64'(qif.count), 64'd2);
    check("deq2_head_pc", 64'(qif.out_pc), 64'h208);
    for (int i = 4; i < 6; i++) begin
      offer(32'h20000000 | 32'(i), 32'h200 + 32'(4 * i));
      step();
    end
    qif.in_valid = 1'b0;
    check("refill_count", 64'(qif.count), 64'd4);
    qif.out_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      check($sformatf("wrap_pc%0d", i), 64'(qif.out_pc), 64'(32'h200 + 32'(4 * i)));
      check($sformatf("wrap_imm%0d", i), 64'(qif.imm16), 64'(i));
      step();
    end
    qif.out_ready = 1'b0;
    check("wrap_empty", 64'(qif.out_valid), 64'd0);

    // 5. Simultaneous enqueue and dequeue at count=2
    offer(32'h2000000A, 32'h300);
    step();
    offer(32'h2000000B, 32'h304);
    step();
    check("sim_start_count", 64'(qif.count), 64'd2);
    qif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'h2000000C + 32'(i), 32'h308 + 32'(4 * i));
      check($sformatf("sim_head%0d", i), 64'(qif.out_pc), 64'(32'h300 + 32'(4 * i)));
      step();
      check($sformatf("sim_count%0d", i), 64'(qif.count), 64'd2);
    end
    qif.in_valid = 1'b0;
    check("sim_tail0", 64'(qif.out_pc), 64'h30C);
    check("sim_tail0_imm", 64'(qif.imm16), 64'h000D);
    step();
    check("sim_tail1", 64'(qif.out_pc), 64'h310);
    step();
    qif.out_ready = 1'b0;
    check("sim_empty", 64'(qif.count), 64'd0);

    // 6. Flush at count=3 with enqueue and dequeue both requested
    for (int i = 0; i < 3; i++) begin
      offer(32'h20000010 + 32'(i), 32'h400 + 32'(4 * i));
      step();
    end
    check("pre_flush_count", 64'(qif.count), 64'd3);
    offer(32'h20000020, 32'h500);
    qif.out_ready = 1'b1;
    flush         = 1'b1;
    #1;
    check("flush_in_ready", 64'(qif.in_ready), 64'd0);
    step();
    flush         = 1'b0;
    qif.in_valid  = 1'b0;
    qif.out_ready = 1'b0;
    check("flush_count", 64'(qif.count), 64'd0);
    check("flush_out_valid", 64'(qif.out_valid), 64'd0);
    step();
    check("flush_not_stored", 64'(qif.count), 64'd0);
    offer(32'h20000030, 32'h600);
    step();
    qif.in_valid = 1'b0;
    check("post_flush_pc", 64'(qif.out_pc), 64'h600);
    check("post_flush_imm", 64'(qif.imm16), 64'h0030);
    check("post_flush_count", 64'(qif.count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
